// File: rtl/srio_dma_pkg.sv
// rtl/srio_dma_pkg.sv - shared encodings for the SRIO DMA combine path
package srio_dma_pkg;

    localparam int CMD_START = 0;
    localparam int CMD_ABORT = 1;
    localparam int CMD_TCHK  = 2;

    localparam int ST_BUSY      = 0;
    localparam int ST_DONE      = 1;
    localparam int ST_LEN_ERR   = 2;
    localparam int ST_TUSER_ERR = 3;
    localparam int ST_CFG_ERR   = 4;
    localparam int ST_ABORTED   = 5;

    localparam logic [7:0] TKEEP_ALL = 8'hff;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DROP,
        S_DRAIN,
        S_FLUSH
    } fsm_state_t;

endpackage

// File: rtl/srio_dma_combine_if.sv
// rtl/srio_dma_combine_if.sv - AXIS stream bundle with master/slave views
interface srio_dma_combine_if #(
    parameter int DW = 64,
    parameter int UW = 32
);
    logic            tvalid;
    logic            tready;
    logic [DW-1:0]   tdata;
    logic            tlast;
    logic [UW-1:0]   tuser;
    logic [DW/8-1:0] tkeep;

    modport master (output tvalid, tdata, tlast, tuser, tkeep, input tready);
    modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/srio_axis_skid.sv
// rtl/srio_axis_skid.sv - two-entry registered skid buffer, one cycle in-to-out latency
module srio_axis_skid #(
    parameter int W = 65
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i,
    output logic         full_o,
    output logic         empty_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_q, rd_q;
    logic [1:0]   cnt_q;
    logic         push, pop;

    assign full_o      = (cnt_q == 2'd2);
    assign empty_o     = (cnt_q == 2'd0);
    assign out_valid_o = ~empty_o;
    assign out_data_o  = mem_q[rd_q];
    assign push        = in_valid_i & ~full_o;
    assign pop         = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= in_data_i;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/srio_dma_combine.sv
// rtl/srio_dma_combine.sv - concatenates num_pkts SRIO packets into one S2MM stream
module srio_dma_combine
    import srio_dma_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               AXIS_ACLK,
    input  logic               AXIS_ARESET,
    srio_dma_combine_if.slave  S_AXIS,
    srio_dma_combine_if.master M_AXIS,
    input  logic [31:0]        cmd,
    input  logic [31:0]        num_pkts,
    input  logic [31:0]        pkt_size,
    input  logic [31:0]        tuser_expect,
    output logic [31:0]        status,
    output logic [31:0]        pkt_count
);
    fsm_state_t       state_q;
    logic             start_prev_q, in_pkt_q, abort_pend_q;
    logic             done_q, len_err_q, tuser_err_q, cfg_err_q, aborted_q;
    logic [CNT_W-1:0] num_q, size_q, pkt_cnt_q, beat_q;
    logic [CNT_W-1:0] pkt_cnt_d, beat_d;
    logic [31:0]      texp_q;
    logic             skid_full, skid_empty, s_ready, s_fire, push, drop_first;
    logic             last_pkt, len_bad, abort_req, start_edge;
    logic [64:0]      skid_out;
    logic             unused_ok;

    assign unused_ok  = ^{cmd[31:3], num_pkts[31:CNT_W], pkt_size[31:CNT_W]};
    assign start_edge = cmd[CMD_START] & ~start_prev_q;
    assign abort_req  = cmd[CMD_ABORT] | abort_pend_q;

    // Between packets an abort must not let a new first beat in.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            S_RUN:   s_ready = ~skid_full & ~(cmd[CMD_ABORT] & ~in_pkt_q);
            S_DROP:  s_ready = 1'b1;
            default: s_ready = 1'b0;
        endcase
    end

    assign S_AXIS.tready = s_ready;
    assign s_fire     = S_AXIS.tvalid & s_ready;
    assign drop_first = (state_q == S_RUN) & ~in_pkt_q & cmd[CMD_TCHK]
                        & (S_AXIS.tuser != texp_q);
    assign push       = (state_q == S_RUN) & s_fire & ~drop_first;
    assign beat_d     = (&beat_q) ? beat_q : beat_q + CNT_W'(1);
    assign pkt_cnt_d  = (&pkt_cnt_q) ? pkt_cnt_q : pkt_cnt_q + CNT_W'(1);
    assign last_pkt   = (({1'b0, pkt_cnt_q} + (CNT_W+1)'(1)) == {1'b0, num_q});
    assign len_bad    = (size_q != '0) &
                        (S_AXIS.tlast ? (beat_d != size_q)
                                      : ({1'b0, beat_d} == ({1'b0, size_q} + (CNT_W+1)'(1))));

    srio_axis_skid #(.W(65)) u_skid (
        .clk_i       (AXIS_ACLK),
        .rst_i       (AXIS_ARESET),
        .in_valid_i  (push),
        .in_data_i   ({S_AXIS.tlast & last_pkt, S_AXIS.tdata}),
        .out_valid_o (M_AXIS.tvalid),
        .out_data_o  (skid_out),
        .out_ready_i (M_AXIS.tready),
        .full_o      (skid_full),
        .empty_o     (skid_empty)
    );

    assign M_AXIS.tdata = skid_out[63:0];
    assign M_AXIS.tlast = skid_out[64];
    assign M_AXIS.tkeep = TKEEP_ALL;
    assign M_AXIS.tuser = '0;

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            in_pkt_q     <= 1'b0;
            abort_pend_q <= 1'b0;
            done_q       <= 1'b0;
            len_err_q    <= 1'b0;
            tuser_err_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
            aborted_q    <= 1'b0;
            num_q        <= '0;
            size_q       <= '0;
            pkt_cnt_q    <= '0;
            beat_q       <= '0;
            texp_q       <= '0;
        end else begin
            start_prev_q <= cmd[CMD_START];
            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        done_q      <= 1'b0;
                        len_err_q   <= 1'b0;
                        tuser_err_q <= 1'b0;
                        aborted_q   <= 1'b0;
                        pkt_cnt_q   <= '0;
                        if (num_pkts[CNT_W-1:0] == '0) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            cfg_err_q    <= 1'b0;
                            num_q        <= num_pkts[CNT_W-1:0];
                            size_q       <= pkt_size[CNT_W-1:0];
                            texp_q       <= tuser_expect;
                            beat_q       <= '0;
                            in_pkt_q     <= 1'b0;
                            abort_pend_q <= 1'b0;
                            state_q      <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (cmd[CMD_ABORT] & in_pkt_q) begin
                        abort_pend_q <= 1'b1;
                    end
                    if (s_fire) begin
                        if (drop_first) begin
                            tuser_err_q <= 1'b1;
                            if (!S_AXIS.tlast) begin
                                state_q <= S_DROP;
                            end
                        end else begin
                            if (len_bad) begin
                                len_err_q <= 1'b1;
                            end
                            if (S_AXIS.tlast) begin
                                beat_q    <= '0;
                                in_pkt_q  <= 1'b0;
                                pkt_cnt_q <= pkt_cnt_d;
                                if (last_pkt) begin
                                    state_q <= S_DRAIN;
                                end else if (abort_req) begin
                                    state_q <= S_FLUSH;
                                end
                            end else begin
                                beat_q   <= beat_d;
                                in_pkt_q <= 1'b1;
                            end
                        end
                    end else if (cmd[CMD_ABORT] & ~in_pkt_q) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_DROP: begin
                    if (cmd[CMD_ABORT]) begin
                        abort_pend_q <= 1'b1;
                    end
                    if (s_fire & S_AXIS.tlast) begin
                        state_q <= abort_req ? S_FLUSH : S_RUN;
                    end
                end
                S_DRAIN: begin
                    if (skid_empty) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (skid_empty) begin
                        aborted_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        status               = '0;
        status[ST_BUSY]      = (state_q != S_IDLE);
        status[ST_DONE]      = done_q;
        status[ST_LEN_ERR]   = len_err_q;
        status[ST_TUSER_ERR] = tuser_err_q;
        status[ST_CFG_ERR]   = cfg_err_q;
        status[ST_ABORTED]   = aborted_q;
    end

    assign pkt_count = {{(32-CNT_W){1'b0}}, pkt_cnt_q};
endmodule

// File: tb/tb_srio_dma_combine.sv
// tb/tb_srio_dma_combine.sv - scoreboard bench for srio_dma_combine
module tb_srio_dma_combine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    srio_dma_combine_if s_if ();
    srio_dma_combine_if m_if ();

    logic [31:0] cmd, num_pkts, pkt_size, tuser_expect, status, pkt_count;

    srio_dma_combine #(.CNT_W(16)) dut (
        .AXIS_ACLK    (clk),
        .AXIS_ARESET  (rst),
        .S_AXIS       (s_if),
        .M_AXIS       (m_if),
        .cmd          (cmd),
        .num_pkts     (num_pkts),
        .pkt_size     (pkt_size),
        .tuser_expect (tuser_expect),
        .status       (status),
        .pkt_count    (pkt_count)
    );

    int          checks = 0;
    int          failures = 0;
    logic [64:0] exp_q [$];
    int          out_beats = 0;
    int          tlast_seen = 0;
    int          m_mode = 0;
    bit          tog = 1'b0;
    bit          prev_stall = 1'b0;
    logic [64:0] prev_beat;

    task automatic check(input string nm, input logic [64:0] act, input logic [64:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // m_mode: 0 always ready, 1 toggling, 2 never ready
    always @(posedge clk) begin
        #1;
        tog = ~tog;
        m_if.tready = (m_mode == 0) ? 1'b1 : (m_mode == 1) ? tog : 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("m_hold_valid", {64'd0, m_if.tvalid}, 65'd1);
                check("m_hold_data", {m_if.tlast, m_if.tdata}, prev_beat);
            end
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL m_beat_unexpected actual=%h required=none", {m_if.tlast, m_if.tdata});
                end else begin
                    check("m_beat", {m_if.tlast, m_if.tdata}, exp_q.pop_front());
                end
                out_beats++;
                if (m_if.tlast) tlast_seen++;
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_beat  = {m_if.tlast, m_if.tdata};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input bit l, input logic [31:0] u,
                             input bit fwd, input bit el);
        int t = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tuser  = u;
        forever begin
            @(negedge clk);
            if (s_if.tready) begin
                if (fwd) exp_q.push_back({el, d});
                tick(1);
                return;
            end
            tick(1);
            t++;
            if (t > 300) begin
                failures++;
                $display("FAIL s_tready_timeout actual=0 required=1");
                return;
            end
        end
    endtask

    task automatic send_pkt(input int tid, input int pid, input int nb, input logic [31:0] u,
                            input bit fwd, input bit fin);
        for (int b = 0; b < nb; b++)
            send_beat({32'(tid * 256 + pid), 32'(b)}, b == nb - 1, u, fwd, fin && (b == nb - 1));
    endtask

    task automatic start(input int n, input int sz, input logic [31:0] texp, input bit chk);
        cmd = 32'd0;
        tick(1);
        num_pkts     = 32'(n);
        pkt_size     = 32'(sz);
        tuser_expect = texp;
        cmd          = {29'd0, chk, 1'b0, 1'b1};
        tick(1);
        out_beats  = 0;
        tlast_seen = 0;
    endtask

    task automatic end_test(input string nm, input logic [31:0] st, input int cnt,
                            input int beats, input int lasts);
        int t = 0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        while (status[0] && t < 2000) begin
            tick(1);
            t++;
        end
        check({nm, "_status"}, 65'(status), 65'(st));
        check({nm, "_pkt_count"}, 65'(pkt_count), 65'(cnt));
        check({nm, "_beats"}, 65'(out_beats), 65'(beats));
        check({nm, "_tlasts"}, 65'(tlast_seen), 65'(lasts));
        check({nm, "_sb_empty"}, 65'(exp_q.size()), 65'd0);
        exp_q.delete();
    endtask

    initial begin
        cmd = 32'd0; num_pkts = 32'd0; pkt_size = 32'd0; tuser_expect = 32'd0;
        s_if.tvalid = 1'b0; s_if.tdata = 64'd0; s_if.tlast = 1'b0;
        s_if.tuser = 32'd0; s_if.tkeep = 8'hff;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_status", 65'(status), 65'd0);
        check("rst_pkt_count", 65'(pkt_count), 65'd0);
        check("rst_m_tvalid", 65'(m_if.tvalid), 65'd0);
        check("rst_m_tkeep", 65'(m_if.tkeep), 65'hff);
        check("rst_s_tready", 65'(s_if.tready), 65'd0);

        // 1: four contiguous 8-beat packets
        start(4, 8, 32'd0, 1'b0);
        for (int p = 0; p < 4; p++) send_pkt(1, p, 8, 32'h0, 1'b1, p == 3);
        end_test("t1", 32'h2, 4, 32, 1);

        // 2: same with a toggling downstream ready
        m_mode = 1;
        start(4, 8, 32'd0, 1'b0);
        for (int p = 0; p < 4; p++) send_pkt(2, p, 8, 32'h0, 1'b1, p == 3);
        end_test("t2", 32'h2, 4, 32, 1);
        m_mode = 0;

        // 3: second packet fails the TUSER compare and is dropped
        start(4, 4, 32'h00010002, 1'b1);
        send_pkt(3, 0, 4, 32'h00010002, 1'b1, 1'b0);
        send_pkt(3, 1, 4, 32'h00010003, 1'b0, 1'b0);
        send_pkt(3, 2, 4, 32'h00010002, 1'b1, 1'b0);
        send_pkt(3, 3, 4, 32'h00010002, 1'b1, 1'b0);
        send_pkt(3, 4, 4, 32'h00010002, 1'b1, 1'b1);
        end_test("t3", 32'hA, 4, 16, 1);

        // 4: short then long packet against pkt_size=8
        start(2, 8, 32'd0, 1'b0);
        send_pkt(4, 0, 6, 32'h0, 1'b1, 1'b0);
        send_pkt(4, 1, 10, 32'h0, 1'b1, 1'b1);
        end_test("t4", 32'h6, 2, 16, 1);

        // 5: abort raised in the middle of packet 2 of 4
        start(4, 8, 32'd0, 1'b0);
        send_pkt(5, 0, 8, 32'h0, 1'b1, 1'b0);
        for (int b = 0; b < 3; b++) send_beat({32'(5 * 256 + 1), 32'(b)}, 1'b0, 32'h0, 1'b1, 1'b0);
        cmd = 32'h3;
        for (int b = 3; b < 8; b++) send_beat({32'(5 * 256 + 1), 32'(b)}, b == 7, 32'h0, 1'b1, 1'b0);
        end_test("t5", 32'h20, 2, 16, 0);

        // 6a: start with num_pkts=0
        start(0, 8, 32'd0, 1'b0);
        check("t6_cfg_status", 65'(status), 65'h10);
        check("t6_cfg_pkt_count", 65'(pkt_count), 65'd0);
        tick(3);
        check("t6_cfg_still_idle", 65'(status), 65'h10);

        // 6b: reset while the skid holds data
        m_mode = 2;
        start(4, 8, 32'd0, 1'b0);
        send_beat(64'h6000_0000_0000_0000, 1'b0, 32'h0, 1'b0, 1'b0);
        send_beat(64'h6000_0000_0000_0001, 1'b0, 32'h0, 1'b0, 1'b0);
        s_if.tvalid = 1'b0;
        @(negedge clk);
        check("t6_pre_rst_m_tvalid", 65'(m_if.tvalid), 65'd1);
        check("t6_pre_rst_busy", 65'(status), 65'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_status", 65'(status), 65'd0);
        check("t6_rst_pkt_count", 65'(pkt_count), 65'd0);
        check("t6_rst_m_tvalid", 65'(m_if.tvalid), 65'd0);
        check("t6_rst_m_tdata", 65'(m_if.tdata), 65'd0);
        check("t6_rst_m_tlast", 65'(m_if.tlast), 65'd0);
        check("t6_rst_m_tkeep", 65'(m_if.tkeep), 65'hff);
        check("t6_rst_s_tready", 65'(s_if.tready), 65'd0);
        cmd = 32'd0;
        m_mode = 0;
        tick(1);
        rst = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
